branch_redirect_unit: RTL and testbench
=======================================

// Module: branch_redirect_unit
// PURPOSE
//  Decode-stage branch resolver and registered redirect generator for the MIPS pipeline.
//  Evaluates the 12 MIPS branch/jump ops and latches a taken target.
//  Holds the redirect until the delay-slot instruction has been fetched.
//  Then presents the redirect to the fetch stage with a valid/ready handshake.
//  Also keeps wrapping branch statistics counters.
// PARAMETERS
//  ADDR_W   32  virtual address / operand width
//  PERF_W   32  width of each statistics counter
// PORTS
//  clk              in   1        core clock
//  reset            in   1        synchronous, active-high reset
//  ds_valid         in   1        decode-stage instruction valid
//  ds_stall         in   1        decode operands not ready (hazard)
//  br_op            in   BR_OP_W  one-hot op: [0]beq [1]bne [2]bgez [3]bgtz [4]blez [5]bltz
//                                 [6]bgezal [7]bltzal [8]j [9]jal [10]jr [11]jalr (+likely, see CONFIG)
//  rs_value         in   ADDR_W   forwarded rs
//  rt_value         in   ADDR_W   forwarded rt
//  delay_slot_pc    in   ADDR_W   PC of the delay-slot instruction (branch PC+4)
//  imm              in   16       branch offset
//  jidx             in   26       jump index
//  slot_fetched     in   1        fetch stage has accepted the delay-slot instruction
//  fs_ready         in   1        fetch stage accepts the redirect this cycle
//  flush            in   1        exception/eret flush (highest priority)
//  br_stall         out  1        decode must hold the current branch
//  redirect_valid   out  1        redirect offered to fetch
//  redirect_target  out  ADDR_W   latched target
//  nullify_slot     out  1        (BRANCH_LIKELY_EN only) kill delay slot
//  br_cnt           out  PERF_W   resolved branches
//  taken_cnt        out  PERF_W   taken branches
// BEHAVIOUR
//  - Condition and target rules:
//      beq: rs==rt.  bne: rs!=rt.  bgez/bgezal: rs>=0.  bgtz: rs>0.
//      blez: rs<=0.  bltz/bltzal: rs<0.  j/jal/jr/jalr: always taken.
//      All compares are signed, on rs[ADDR_W-1] and zero-detect.
//      j/jal target = {delay_slot_pc[31:28], jidx, 2'b00}.
//      jr/jalr target = rs_value.
//      bXX target = delay_slot_pc + sext(imm)<<2, modulo 2^ADDR_W (wraps).
//  - br_stall = ds_valid & |br_op & (ds_stall | state!=IDLE).
//      This is combinational.
//  - resolve = ds_valid & |br_op & ~br_stall & ~flush.
//      Resolution happens exactly once per branch.
//  - FSM states IDLE, WAIT_SLOT, REDIRECT. Transitions are registered.
//      IDLE: on resolve & taken, latch target.
//        If slot_fetched is also high -> REDIRECT, else -> WAIT_SLOT.
//        On resolve & not taken, stay in IDLE.
//      WAIT_SLOT: slot_fetched -> REDIRECT.
//      REDIRECT: fs_ready -> IDLE.
//  - redirect_valid = (state==REDIRECT) & ~flush.
//      redirect_target is stable while valid.
//  - Latency: redirect_valid rises, at the earliest, 1 cycle after the resolve cycle.
//  - flush in any state -> IDLE next cycle.
//      flush has priority over resolve, slot_fetched and fs_ready.
//      A flushed redirect is never completed.
//  - Counters: br_cnt +1 on every resolve; taken_cnt +1 on resolve & taken.
//      Both wrap from 2^PERF_W-1 to 0. Neither changes while flush is high.
//  - Reset: state=IDLE, redirect_target=0, counters=0, nullify_slot=0.
//      All outputs are low while reset is high.
//      A reset mid-operation drops a pending redirect.
// CONFIGURATION
//  BRANCH_LIKELY_EN defined:
//    - BR_OP_W=16; bits [12]beql [13]bnel [14]blezl [15]bgtzl use the beq/bne/blez/bgtz conditions.
//    - A not-taken likely branch pulses nullify_slot for 1 cycle, the cycle after resolve.
//    - The FSM stays in IDLE in that case.
//  BRANCH_LIKELY_EN undefined:
//    - BR_OP_W=12.
//    - nullify_slot is tied to 0.
// TESTING
//  - beq rs=rt=5, delay_slot_pc=0x1000, imm=0x0004, slot_fetched=1 ->
//    redirect_valid next cycle, target 0x1010; with fs_ready=1 -> IDLE.
//  - bne rs=rt -> no redirect; br_cnt +1, taken_cnt unchanged.
//  - jal, delay_slot_pc=0xBFC00004, jidx=0x0000100 -> target 0xB0000400.
//    Holds WAIT_SLOT for 3 cycles with slot_fetched=0.
//  - In REDIRECT with fs_ready=0 for 4 cycles: valid and target stay stable;
//    a second branch sees br_stall=1; fs_ready=1 -> second branch resolves next cycle.
//  - flush while in WAIT_SLOT or REDIRECT -> redirect_valid=0 the same cycle, IDLE next;
//    flush coincident with resolve -> counters unchanged.
//  - bgtz rs=0x80000000 not taken; bltz taken; imm=0x8000 at delay_slot_pc=0x10 -> target 0xFFFE0010.
//    With BRANCH_LIKELY_EN, bnel rs=rt -> nullify_slot for 1 cycle.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Decode-stage branch resolver for the MIPS pipeline. It evaluates the
//   branch/jump condition and the target address. It latches the target of a
//   taken branch and waits until the delay-slot instruction has been fetched.
//   It then offers the redirect to fetch with a valid/ready handshake. It also
//   keeps wrapping statistics counters for resolved and taken branches.
//
//   Optional feature macro: BRANCH_LIKELY_EN
//     When defined, the branch-likely ops are added (br_op widens to 16 bits).
//     A not-taken likely branch pulses nullify_slot.
//     When undefined, br_op is 12 bits and nullify_slot is tied low.
//
// Ports
//   clk, reset       core clock, synchronous active-high reset
//   ds_valid         decode-stage instruction valid
//   ds_stall         decode operands not ready
//   br_op            one-hot op: [0]beq [1]bne [2]bgez [3]bgtz [4]blez [5]bltz
//                    [6]bgezal [7]bltzal [8]j [9]jal [10]jr [11]jalr
//                    (+ [12]beql [13]bnel [14]blezl [15]bgtzl when likely enabled)
//   rs_value         forwarded rs
//   rt_value         forwarded rt
//   delay_slot_pc    PC of the delay-slot instruction
//   imm              16-bit branch offset
//   jidx             26-bit jump index
//   slot_fetched     fetch has accepted the delay-slot instruction
//   fs_ready         fetch accepts the redirect this cycle
//   flush            exception/eret flush, highest priority
//   br_stall         decode must hold the current branch
//   redirect_valid   redirect offered to fetch
//   redirect_target  latched redirect target
//   nullify_slot     kill the delay slot (likely branches only)
//   br_cnt           resolved-branch counter
//   taken_cnt        taken-branch counter
module branch_redirect_unit #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32,
`ifdef BRANCH_LIKELY_EN
  localparam int BR_OP_W = 16
`else
  localparam int BR_OP_W = 12
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ds_valid,
  input  logic               ds_stall,
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [ADDR_W-1:0]  rs_value,
  input  logic [ADDR_W-1:0]  rt_value,
  input  logic [ADDR_W-1:0]  delay_slot_pc,
  input  logic [15:0]        imm,
  input  logic [25:0]        jidx,
  input  logic               slot_fetched,
  input  logic               fs_ready,
  input  logic               flush,
  output logic               br_stall,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_target,
  output logic               nullify_slot,
  output logic [PERF_W-1:0]  br_cnt,
  output logic [PERF_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    REDIRECT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   target_q;
  logic [PERF_W-1:0]   br_cnt_q;
  logic [PERF_W-1:0]   taken_cnt_q;

  logic                is_branch;
  logic                resolve;
  logic                taken;
  logic                rs_neg;
  logic                rs_zero;
  logic                rs_eq_rt;
  logic [BR_OP_W-1:0]  cond_vec;
  logic [ADDR_W-1:0]   branch_target;
  logic [ADDR_W-1:0]   jump_target;
  logic [ADDR_W-1:0]   target_d;

  // Signed compares against zero only need the sign bit and a zero detect,
  // so no magnitude comparator is built.
  always_comb begin
    rs_neg   = rs_value[ADDR_W-1];
    rs_zero  = ~|rs_value;
    rs_eq_rt = (rs_value == rt_value);
    cond_vec = '0;
    cond_vec[0]  = rs_eq_rt;
    cond_vec[1]  = ~rs_eq_rt;
    cond_vec[2]  = ~rs_neg;
    cond_vec[3]  = ~rs_neg & ~rs_zero;
    cond_vec[4]  = rs_neg | rs_zero;
    cond_vec[5]  = rs_neg;
    cond_vec[6]  = ~rs_neg;
    cond_vec[7]  = rs_neg;
    cond_vec[8]  = 1'b1;
    cond_vec[9]  = 1'b1;
    cond_vec[10] = 1'b1;
    cond_vec[11] = 1'b1;
`ifdef BRANCH_LIKELY_EN
    cond_vec[12] = rs_eq_rt;
    cond_vec[13] = ~rs_eq_rt;
    cond_vec[14] = rs_neg | rs_zero;
    cond_vec[15] = ~rs_neg & ~rs_zero;
`endif
    taken = |(br_op & cond_vec);
  end

  // Target selection. The PC-relative add wraps naturally at ADDR_W bits.
  always_comb begin
    branch_target = delay_slot_pc + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    jump_target   = {delay_slot_pc[31:28], jidx, 2'b00};
    target_d      = branch_target;
    if (br_op[8] || br_op[9]) begin
      target_d = jump_target;
    end else if (br_op[10] || br_op[11]) begin
      target_d = rs_value;
    end
  end

  // A branch is held in decode while operands are missing or an earlier
  // redirect is still in flight; it resolves only on the cycle it is released.
  always_comb begin
    is_branch = ds_valid & (|br_op);
    br_stall  = ~reset & is_branch & (ds_stall | (state_q != IDLE));
    resolve   = is_branch & ~br_stall & ~flush;
  end

  // Next-state logic. Flush overrides every other transition so that a
  // flushed redirect is never completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (resolve && taken) begin
          state_d = slot_fetched ? REDIRECT : WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (slot_fetched) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (fs_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The target is captured only when a taken branch resolves, so it stays
  // stable for the whole time the redirect is offered.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
    end else if (resolve && taken) begin
      target_q <= target_d;
    end
  end

  // Statistics counters; resolve already excludes flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (resolve) begin
      br_cnt_q <= br_cnt_q + PERF_W'(1);
      if (taken) begin
        taken_cnt_q <= taken_cnt_q + PERF_W'(1);
      end
    end
  end

`ifdef BRANCH_LIKELY_EN
  logic nullify_q;

  // A not-taken likely branch kills its delay slot the cycle after resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      nullify_q <= 1'b0;
    end else begin
      nullify_q <= resolve & (|br_op[15:12]) & ~taken;
    end
  end

  assign nullify_slot = nullify_q & ~reset;
`else
  assign nullify_slot = 1'b0;
`endif

  // Registered outputs are forced low while reset is held, even before the
  // first reset edge has cleared the registers.
  assign redirect_valid  = ~reset & (state_q == REDIRECT) & ~flush;
  assign redirect_target = reset ? '0 : target_q;
  assign br_cnt          = reset ? '0 : br_cnt_q;
  assign taken_cnt       = reset ? '0 : taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit
//   Directed bench for branch_redirect_unit. A behavioural model tracks
//   whether a redirect is pending, whether its slot has been fetched, the
//   latched target and the counters. The outputs are compared against it every
//   cycle, and hand-computed literal values pin the key scenarios. Counters are
//   narrowed to 4 bits so that wrap-around is reachable.
module tb_branch_redirect_unit;

`ifdef BRANCH_LIKELY_EN
  localparam int OPW = 16;
`else
  localparam int OPW = 12;
`endif
  localparam int PW = 4;

  logic           clk;
  logic           reset;
  logic           ds_valid;
  logic           ds_stall;
  logic [OPW-1:0] br_op;
  logic [31:0]    rs_value;
  logic [31:0]    rt_value;
  logic [31:0]    delay_slot_pc;
  logic [15:0]    imm;
  logic [25:0]    jidx;
  logic           slot_fetched;
  logic           fs_ready;
  logic           flush;
  logic           br_stall;
  logic           redirect_valid;
  logic [31:0]    redirect_target;
  logic           nullify_slot;
  logic [PW-1:0]  br_cnt;
  logic [PW-1:0]  taken_cnt;

  int checks = 0;
  int errors = 0;

  // Model: a pending redirect, whether its delay slot is in, its target.
  bit          m_busy = 0;
  bit          m_slot = 0;
  logic [31:0] m_tgt = 0;
  int          m_br = 0;
  int          m_tk = 0;
  bit          m_null = 0;

  branch_redirect_unit #(.ADDR_W(32), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_stall(ds_stall),
    .br_op(br_op), .rs_value(rs_value), .rt_value(rt_value),
    .delay_slot_pc(delay_slot_pc), .imm(imm), .jidx(jidx),
    .slot_fetched(slot_fetched), .fs_ready(fs_ready), .flush(flush),
    .br_stall(br_stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .nullify_slot(nullify_slot),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the single op bit set, or -1.
  function automatic int op_index(input logic [OPW-1:0] op);
    int r = -1;
    for (int i = 0; i < OPW; i++) if (op[i]) r = i;
    return r;
  endfunction

  function automatic bit model_taken(input int idx, input logic [31:0] rs, input logic [31:0] rt);
    int signed s = $signed(rs);
    case (idx)
      0, 12:  return rs == rt;
      1, 13:  return rs != rt;
      2, 6:   return s >= 0;
      3, 15:  return s > 0;
      4, 14:  return s <= 0;
      5, 7:   return s < 0;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input int idx, input logic [31:0] rs,
                                               input logic [31:0] pc, input logic [15:0] im,
                                               input logic [25:0] ji);
    int signed off;
    if (idx == 8 || idx == 9) return (pc & 32'hF000_0000) | ({6'b0, ji} << 2);
    if (idx == 10 || idx == 11) return rs;
    off = $signed(im);
    return pc + 32'(off * 4);
  endfunction

  // Model update on each rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    bit stall_now;
    bit res;
    int idx;
    if (reset) begin
      m_busy = 0; m_slot = 0; m_tgt = 0; m_br = 0; m_tk = 0; m_null = 0;
    end else begin
      idx = op_index(br_op);
      stall_now = ds_valid && (idx >= 0) && (ds_stall || m_busy);
      res = ds_valid && (idx >= 0) && !stall_now && !flush;
      m_null = 0;
      if (flush) begin
        m_busy = 0; m_slot = 0;
      end else if (m_busy) begin
        if (m_slot && fs_ready) m_busy = 0;
        else if (!m_slot && slot_fetched) m_slot = 1;
      end else if (res) begin
        m_br = (m_br + 1) % (2 ** PW);
        if (model_taken(idx, rs_value, rt_value)) begin
          m_tk = (m_tk + 1) % (2 ** PW);
          m_busy = 1;
          m_slot = slot_fetched;
          m_tgt = model_target(idx, rs_value, delay_slot_pc, imm, jidx);
        end else if (idx >= 12) begin
          m_null = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit e_stall;
    if (reset) begin
      checkOutput("rst_br_stall", {31'b0, br_stall}, 0);
      checkOutput("rst_valid", {31'b0, redirect_valid}, 0);
      checkOutput("rst_target", redirect_target, 0);
      checkOutput("rst_nullify", {31'b0, nullify_slot}, 0);
      checkOutput("rst_br_cnt", 32'(br_cnt), 0);
      checkOutput("rst_taken_cnt", 32'(taken_cnt), 0);
    end else begin
      e_stall = ds_valid && (|br_op) && (ds_stall || m_busy);
      checkOutput("br_stall", {31'b0, br_stall}, {31'b0, e_stall});
      checkOutput("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_busy && m_slot && !flush});
      checkOutput("redirect_target", redirect_target, m_tgt);
      checkOutput("nullify_slot", {31'b0, nullify_slot}, {31'b0, m_null});
      checkOutput("br_cnt", 32'(br_cnt), 32'(m_br));
      checkOutput("taken_cnt", 32'(taken_cnt), 32'(m_tk));
    end
  end

  task automatic applyStimulus(input logic v, input logic st, input int idx,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] pc, input logic [15:0] im,
                               input logic [25:0] ji, input logic sf,
                               input logic fr, input logic fl);
    ds_valid = v; ds_stall = st;
    br_op = (idx < 0) ? '0 : (OPW'(1) << idx);
    rs_value = rs; rt_value = rt; delay_slot_pc = pc; imm = im; jidx = ji;
    slot_fetched = sf; fs_ready = fr; flush = fl;
  endtask

  task automatic quiet(input logic sf, input logic fr, input logic fl);
    applyStimulus(0, 0, -1, 0, 0, 0, 0, 0, sf, fr, fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [15:0] im;
    logic [25:0] ji;
  } vec_t;

  vec_t vecs[9];

  initial begin
    reset = 1'b1;
    quiet(0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("lit_reset_br_cnt", 32'(br_cnt), 0);

    // beq taken with slot already fetched: redirect the next cycle.
    applyStimulus(1, 0, 0, 5, 5, 32'h1000, 16'h0004, 0, 1, 0, 0);
    tick();
    checkOutput("lit_beq_valid", {31'b0, redirect_valid}, 1);
    checkOutput("lit_beq_target", redirect_target, 32'h0000_1010);
    quiet(0, 1, 0);
    tick();
    checkOutput("lit_beq_accepted", {31'b0, redirect_valid}, 0);

    // bne with equal operands is not taken.
    applyStimulus(1, 0, 1, 5, 5, 32'h1000, 16'h0004, 0, 1, 0, 0);
    tick();
    quiet(0, 0, 0);
    #1;
    checkOutput("lit_bne_br_cnt", 32'(br_cnt), 2);
    checkOutput("lit_bne_taken_cnt", 32'(taken_cnt), 1);
    checkOutput("lit_bne_valid", {31'b0, redirect_valid}, 0);

    // jal waits for its delay slot.
    applyStimulus(1, 0, 9, 0, 0, 32'hBFC0_0004, 0, 26'h0000100, 0, 0, 0);
    tick();
    quiet(0, 0, 0);
    repeat (3) tick();
    checkOutput("lit_jal_wait_valid", {31'b0, redirect_valid}, 0);
    quiet(1, 0, 0);
    tick();
    checkOutput("lit_jal_valid", {31'b0, redirect_valid}, 1);
    checkOutput("lit_jal_target", redirect_target, 32'hB000_0400);

    // Fetch not ready for 4 cycles while a second branch waits in decode.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 7, 7, 32'h2000, 16'h0001, 0, 1, 0, 0);
      tick();
      checkOutput("lit_hold_valid", {31'b0, redirect_valid}, 1);
      checkOutput("lit_hold_target", redirect_target, 32'hB000_0400);
      checkOutput("lit_hold_stall", {31'b0, br_stall}, 1);
    end
    applyStimulus(1, 0, 0, 7, 7, 32'h2000, 16'h0001, 0, 1, 1, 0);
    tick();
    checkOutput("lit_second_released", {31'b0, br_stall}, 0);
    applyStimulus(1, 0, 0, 7, 7, 32'h2000, 16'h0001, 0, 1, 0, 0);
    tick();
    checkOutput("lit_second_target", redirect_target, 32'h0000_2004);
    checkOutput("lit_second_br_cnt", 32'(br_cnt), 4);
    quiet(0, 1, 0);
    tick();

    // Flush while waiting for the slot.
    applyStimulus(1, 0, 8, 0, 0, 32'h0040_0004, 0, 26'h10, 0, 0, 0);
    tick();
    quiet(1, 0, 1);
    tick();
    quiet(1, 0, 0);
    tick();
    checkOutput("lit_flush_wait_valid", {31'b0, redirect_valid}, 0);

    // Flush while the redirect is offered.
    applyStimulus(1, 0, 0, 1, 1, 32'h3000, 0, 0, 1, 0, 0);
    tick();
    quiet(0, 0, 1);
    #1;
    checkOutput("lit_flush_same_cycle", {31'b0, redirect_valid}, 0);
    tick();
    quiet(0, 0, 0);
    #1;
    checkOutput("lit_flush_next_idle", {31'b0, redirect_valid}, 0);

    // Flush coincident with resolve.
    applyStimulus(1, 0, 0, 3, 3, 32'h4000, 0, 0, 1, 0, 1);
    tick();
    quiet(0, 0, 0);
    #1;
    checkOutput("lit_flush_res_br", 32'(br_cnt), 6);
    checkOutput("lit_flush_res_tk", 32'(taken_cnt), 5);

    // Sign tests and negative offset wrap.
    applyStimulus(1, 0, 3, 32'h8000_0000, 0, 32'h10, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 5, 32'h8000_0000, 0, 32'h10, 16'h8000, 0, 1, 0, 0);
    tick();
    checkOutput("lit_bltz_target", redirect_target, 32'hFFFE_0010);
    checkOutput("lit_bltz_br_cnt", 32'(br_cnt), 8);
    quiet(0, 1, 0);
    tick();

    // Operand hazard keeps the branch stalled without resolving.
    applyStimulus(1, 1, 0, 2, 2, 32'h500, 0, 0, 1, 0, 0);
    #1;
    checkOutput("lit_ds_stall", {31'b0, br_stall}, 1);
    tick();
    quiet(0, 0, 0);
    tick();

    // Remaining ops, checked by the model.
    vecs[0] = '{10, 32'h1234_5678, 0, 32'h100, 0, 0};
    vecs[1] = '{4, 0, 0, 32'h200, 16'h0010, 0};
    vecs[2] = '{2, 32'hFFFF_FFFF, 0, 32'h300, 16'h0010, 0};
    vecs[3] = '{6, 0, 0, 32'h400, 16'hFFFF, 0};
    vecs[4] = '{7, 1, 0, 32'h500, 16'h0020, 0};
    vecs[5] = '{11, 32'h80, 0, 32'h600, 0, 0};
    vecs[6] = '{3, 1, 0, 32'h700, 16'h0003, 0};
    vecs[7] = '{1, 1, 2, 32'h800, 16'h7FFF, 0};
    vecs[8] = '{8, 0, 0, 32'h9000_0000, 0, 26'h3FF_FFFF};
    foreach (vecs[i]) begin
      applyStimulus(1, 0, vecs[i].idx, vecs[i].rs, vecs[i].rt, vecs[i].pc,
                    vecs[i].im, vecs[i].ji, 1, 0, 0);
      tick();
      quiet(0, 1, 0);
      tick();
    end

    // Outputs held low during reset even with a stalled branch present.
    reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("lit_reset_stall_low", {31'b0, br_stall}, 0);
    tick(); tick();
    reset = 1'b0;
    quiet(0, 0, 0);

    // Counter wrap: 17 back-to-back not-taken branches on a 4-bit counter.
    applyStimulus(1, 0, 1, 9, 9, 32'h100, 0, 0, 0, 0, 0);
    repeat (17) tick();
    quiet(0, 0, 0);
    #1;
    checkOutput("lit_wrap_br_cnt", 32'(br_cnt), 1);
    checkOutput("lit_wrap_taken_cnt", 32'(taken_cnt), 0);

    // Reset drops a pending redirect.
    applyStimulus(1, 0, 0, 4, 4, 32'h700, 16'h0002, 0, 0, 0, 0);
    tick();
    quiet(0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    quiet(1, 0, 0);
    tick();
    checkOutput("lit_reset_drop_valid", {31'b0, redirect_valid}, 0);
    checkOutput("lit_reset_drop_target", redirect_target, 0);

`ifdef BRANCH_LIKELY_EN
    // bnel with equal operands nullifies the slot for one cycle.
    applyStimulus(1, 0, 13, 6, 6, 32'h100, 0, 0, 1, 0, 0);
    tick();
    quiet(0, 0, 0);
    #1;
    checkOutput("lit_bnel_nullify", {31'b0, nullify_slot}, 1);
    tick();
    checkOutput("lit_bnel_nullify_end", {31'b0, nullify_slot}, 0);
`endif

    quiet(0, 0, 0);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
